// File: rtl/bubble_page_loader.sv
// Fetches one page image byte-by-byte from image memory and unpacks each byte
// into four 2-bit bubble buffer entries, strobing the buffer write port per entry.
module bubble_page_loader #(
   parameter int                    ADDR_WIDTH      = 22,
   parameter int                    PAGE_ENTRIES    = 1920,
   parameter logic [ADDR_WIDTH-1:0] BOOTLOADER_BASE = '0
) (
   input  logic                  master_clock,
   input  logic                  power_good,
   input  logic                  load_page,
   input  logic                  load_bootloader,
   input  logic [ADDR_WIDTH-1:0] start_of_page_address,
   output logic                  mem_read_request,
   output logic [ADDR_WIDTH-1:0] mem_address,
   input  logic [7:0]            mem_data,
   input  logic                  mem_data_valid,
   output logic [10:0]           bubble_buffer_write_address,
   output logic [1:0]            bubble_buffer_data_input,
   output logic                  bubble_buffer_write_enable,
   output logic                  bubble_buffer_write_clock,
   output logic                  loader_busy,
   output logic                  loader_done
);

   localparam logic [10:0] LAST_ENTRY = 11'(PAGE_ENTRIES - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      SETUP = 3'd2,
      HIGH  = 3'd3,
      HOLD  = 3'd4,
      DONE  = 3'd5
   } state_t;

   state_t          state, state_next;
   logic            load_page_q, load_bootloader_q;
   logic            page_edge, boot_edge, start;
   logic [7:0]      byte_reg;
   logic [1:0]      pair_idx;
   logic [10:0]     entry_idx;

   assign page_edge = load_page & ~load_page_q;
   assign boot_edge = load_bootloader & ~load_bootloader_q;

   always_ff @(posedge master_clock or negedge power_good) begin
      if (!power_good) begin
         load_page_q       <= 1'b0;
         load_bootloader_q <= 1'b0;
      end else begin
         load_page_q       <= load_page;
         load_bootloader_q <= load_bootloader;
      end
   end

   always_ff @(posedge master_clock or negedge power_good) begin
      if (!power_good) state <= IDLE;
      else             state <= state_next;
   end

   always_comb begin
      state_next = state;
      start      = 1'b0;
      case (state)
         IDLE: begin
            if (page_edge || boot_edge) begin
               state_next = FETCH;
               start      = 1'b1;
            end
         end
         FETCH: if (mem_data_valid) state_next = SETUP;
         SETUP: state_next = HIGH;
         HIGH:  state_next = HOLD;
         HOLD: begin
            if (pair_idx != 2'd3)          state_next = SETUP;
            else if (entry_idx < LAST_ENTRY) state_next = FETCH;
            else                           state_next = DONE;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Once the first entry is set up, write enable stays asserted across later FETCH gaps.
   always_comb begin
      mem_read_request           = (state == FETCH);
      loader_busy                = (state != IDLE);
      loader_done                = (state == DONE);
      bubble_buffer_write_clock  = (state == HIGH);
      bubble_buffer_write_enable = !((state == SETUP) || (state == HIGH) || (state == HOLD) ||
                                     ((state == FETCH) && (entry_idx != 11'd0)));
      bubble_buffer_write_address = entry_idx;
      case (pair_idx)
         2'd0:    bubble_buffer_data_input = byte_reg[7:6];
         2'd1:    bubble_buffer_data_input = byte_reg[5:4];
         2'd2:    bubble_buffer_data_input = byte_reg[3:2];
         default: bubble_buffer_data_input = byte_reg[1:0];
      endcase
   end

   always_ff @(posedge master_clock or negedge power_good) begin
      if (!power_good) begin
         mem_address <= '0;
         byte_reg    <= 8'd0;
         pair_idx    <= 2'd0;
         entry_idx   <= 11'd0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  mem_address <= boot_edge ? BOOTLOADER_BASE : start_of_page_address;
                  pair_idx    <= 2'd0;
                  entry_idx   <= 11'd0;
               end
            end
            FETCH: begin
               if (mem_data_valid) begin
                  byte_reg <= mem_data;
                  pair_idx <= 2'd0;
               end
            end
            HOLD: begin
               if (pair_idx != 2'd3) begin
                  pair_idx  <= pair_idx + 2'd1;
                  entry_idx <= entry_idx + 11'd1;
               end else if (entry_idx < LAST_ENTRY) begin
                  entry_idx   <= entry_idx + 11'd1;
                  mem_address <= mem_address + ADDR_WIDTH'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bubble_page_loader.sv
// Scoreboard bench for bubble_page_loader: a memory responder pushes expected
// buffer writes per byte served, a write monitor pops and compares each strobe.
`timescale 1ns/1ps
module tb_bubble_page_loader;

   logic        master_clock = 1'b0;
   logic        power_good = 1'b0;
   logic        load_page = 1'b0;
   logic        load_bootloader = 1'b0;
   logic [21:0] start_of_page_address = 22'd0;
   logic        mem_read_request;
   logic [21:0] mem_address;
   logic [7:0]  mem_data;
   logic        mem_data_valid;
   logic [10:0] bubble_buffer_write_address;
   logic [1:0]  bubble_buffer_data_input;
   logic        bubble_buffer_write_enable;
   logic        bubble_buffer_write_clock;
   logic        loader_busy;
   logic        loader_done;

   always #5 master_clock = ~master_clock;

   bubble_page_loader dut (
      .master_clock                (master_clock),
      .power_good                  (power_good),
      .load_page                   (load_page),
      .load_bootloader             (load_bootloader),
      .start_of_page_address       (start_of_page_address),
      .mem_read_request            (mem_read_request),
      .mem_address                 (mem_address),
      .mem_data                    (mem_data),
      .mem_data_valid              (mem_data_valid),
      .bubble_buffer_write_address (bubble_buffer_write_address),
      .bubble_buffer_data_input    (bubble_buffer_data_input),
      .bubble_buffer_write_enable  (bubble_buffer_write_enable),
      .bubble_buffer_write_clock   (bubble_buffer_write_clock),
      .loader_busy                 (loader_busy),
      .loader_done                 (loader_done)
   );

   int checks = 0;
   int failures = 0;
   int fetch_n = 0;
   int mem_wait = 0;
   int done_cnt = 0;
   logic [21:0] exp_addr_q[$];
   logic [12:0] exp_wr_q[$];
   logic [21:0] req_log[$];
   logic [12:0] wr_log[$];
   logic [12:0] mon_e;
   logic [1:0]  first8[8] = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic logic [7:0] byte_of(input int n);
      if (n == 0)      byte_of = 8'hE4;
      else if (n == 1) byte_of = 8'h1B;
      else             byte_of = 8'(n * 37 + 5);
   endfunction

   // Memory responder: checks each requested address, serves a byte after mem_wait cycles.
   initial begin
      logic [21:0] a;
      logic [7:0]  b;
      logic        aborted;
      mem_data = 8'd0;
      mem_data_valid = 1'b0;
      forever begin
         @(negedge master_clock);
         mem_data_valid = 1'b0;
         if (power_good && mem_read_request) begin
            a = mem_address;
            req_log.push_back(a);
            chk("req_expected", exp_addr_q.size() != 0, 1);
            if (exp_addr_q.size() != 0) chk("mem_address", a, exp_addr_q.pop_front());
            aborted = 1'b0;
            for (int i = 0; i < mem_wait; i++) begin
               @(negedge master_clock);
               if (!power_good) begin
                  aborted = 1'b1;
                  break;
               end
               chk("req_held", mem_read_request, 1);
               chk("addr_stable", mem_address, a);
               if (fetch_n > 0) chk("we_low_in_wait", bubble_buffer_write_enable, 0);
            end
            if (!aborted) begin
               b = byte_of(fetch_n);
               for (int j = 0; j < 4; j++)
                  exp_wr_q.push_back({11'(4 * fetch_n + j), b[7 - 2 * j -: 2]});
               fetch_n++;
               mem_data = b;
               mem_data_valid = 1'b1;
            end
         end
      end
   end

   always @(negedge master_clock) begin
      if (power_good) begin
         if (loader_done) done_cnt++;
         if (bubble_buffer_write_clock) begin
            wr_log.push_back({bubble_buffer_write_address, bubble_buffer_data_input});
            chk("we_low_on_strobe", bubble_buffer_write_enable, 0);
            chk("write_expected", exp_wr_q.size() != 0, 1);
            if (exp_wr_q.size() != 0) begin
               mon_e = exp_wr_q.pop_front();
               chk("wr_addr", bubble_buffer_write_address, mon_e[12:2]);
               chk("wr_data", bubble_buffer_data_input, mon_e[1:0]);
            end
         end
      end
   end

   task automatic prep_load(input logic [21:0] base, input int wait_cycles);
      exp_addr_q.delete();
      exp_wr_q.delete();
      req_log.delete();
      wr_log.delete();
      fetch_n = 0;
      mem_wait = wait_cycles;
      for (int i = 0; i < 480; i++) exp_addr_q.push_back(base + 22'(i));
   endtask

   task automatic start_pulse(input logic page, input logic boot, input logic [21:0] exp_base);
      @(negedge master_clock);
      load_page = page;
      load_bootloader = boot;
      @(negedge master_clock);
      chk("start_busy", loader_busy, 1);
      chk("start_req", mem_read_request, 1);
      chk("start_addr", mem_address, exp_base);
      load_page = 1'b0;
      load_bootloader = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      int c;
      int d0;
      c = 0;
      d0 = done_cnt;
      while (done_cnt == d0 && c < budget) begin
         @(negedge master_clock);
         c++;
      end
      chk({name, "_done_in_time"}, done_cnt != d0, 1);
      repeat (5) @(negedge master_clock);
      chk({name, "_idle_after"}, loader_busy, 0);
      chk({name, "_single_done"}, done_cnt - d0, 1);
      chk({name, "_we_high_after"}, bubble_buffer_write_enable, 1);
   endtask

   task automatic wait_addr(input logic [10:0] target, input int budget);
      int c;
      c = 0;
      while (bubble_buffer_write_address != target && c < budget) begin
         @(negedge master_clock);
         c++;
      end
      chk("reached_entry", bubble_buffer_write_address, target);
   endtask

   task automatic check_full(input string name);
      chk({name, "_req_count"}, req_log.size(), 480);
      chk({name, "_wr_count"}, wr_log.size(), 1920);
      if (wr_log.size() == 1920) chk({name, "_last_addr"}, wr_log[1919][12:2], 1919);
      chk({name, "_wr_q_drained"}, exp_wr_q.size(), 0);
   endtask

   initial begin
      int d0;
      // reset and idle
      #3;
      chk("rst_req", mem_read_request, 0);
      chk("rst_we", bubble_buffer_write_enable, 1);
      chk("rst_busy", loader_busy, 0);
      @(negedge master_clock);
      power_good = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge master_clock);
         chk("idle_we", bubble_buffer_write_enable, 1);
         chk("idle_wclk", bubble_buffer_write_clock, 0);
         chk("idle_req", mem_read_request, 0);
         chk("idle_busy", loader_busy, 0);
      end

      // page load, 1-cycle memory
      start_of_page_address = 22'h001000;
      prep_load(22'h001000, 0);
      start_pulse(1'b1, 1'b0, 22'h001000);
      wait_done("page", 10000);
      check_full("page");
      if (req_log.size() >= 2) begin
         chk("page_req0", req_log[0], 22'h001000);
         chk("page_req1", req_log[1], 22'h001001);
      end
      if (wr_log.size() >= 8) begin
         for (int i = 0; i < 8; i++) begin
            chk("first8_addr", wr_log[i][12:2], 11'(i));
            chk("first8_data", wr_log[i][1:0], first8[i]);
         end
      end

      // bootloader priority
      start_of_page_address = 22'h0ABCDE;
      prep_load(22'h000000, 0);
      start_pulse(1'b1, 1'b1, 22'h000000);
      wait_done("boot", 10000);
      check_full("boot");
      for (int i = 0; i < 5; i++) begin
         @(negedge master_clock);
         chk("boot_no_page_restart", loader_busy, 0);
      end

      // busy protection
      start_of_page_address = 22'h000040;
      prep_load(22'h000040, 0);
      start_pulse(1'b1, 1'b0, 22'h000040);
      wait_addr(11'd100, 2000);
      start_of_page_address = 22'h002000;
      load_page = 1'b1;
      @(negedge master_clock);
      @(negedge master_clock);
      load_page = 1'b0;
      wait_done("busy", 10000);
      check_full("busy");

      // memory wait and address wrap
      start_of_page_address = 22'h3FFFFE;
      prep_load(22'h3FFFFE, 5);
      start_pulse(1'b1, 1'b0, 22'h3FFFFE);
      wait_done("wrap", 15000);
      check_full("wrap");
      if (req_log.size() >= 3) begin
         chk("wrap_req0", req_log[0], 22'h3FFFFE);
         chk("wrap_req1", req_log[1], 22'h3FFFFF);
         chk("wrap_req2", req_log[2], 22'h000000);
      end

      // reset mid-load
      start_of_page_address = 22'h000200;
      prep_load(22'h000200, 0);
      start_pulse(1'b1, 1'b0, 22'h000200);
      wait_addr(11'd700, 4000);
      d0 = done_cnt;
      #2 power_good = 1'b0;
      #1;
      chk("arst_req", mem_read_request, 0);
      chk("arst_addr", mem_address, 0);
      chk("arst_wa", bubble_buffer_write_address, 0);
      chk("arst_wd", bubble_buffer_data_input, 0);
      chk("arst_we", bubble_buffer_write_enable, 1);
      chk("arst_wclk", bubble_buffer_write_clock, 0);
      chk("arst_busy", loader_busy, 0);
      chk("arst_done", loader_done, 0);
      exp_addr_q.delete();
      exp_wr_q.delete();
      repeat (3) @(negedge master_clock);
      power_good = 1'b1;
      repeat (5) @(negedge master_clock);
      chk("arst_no_done", done_cnt, d0);
      chk("arst_idle", loader_busy, 0);
      start_of_page_address = 22'h000300;
      prep_load(22'h000300, 0);
      start_pulse(1'b1, 1'b0, 22'h000300);
      wait_done("restart", 10000);
      check_full("restart");
      if (wr_log.size() > 0) chk("restart_first_addr", wr_log[0][12:2], 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
